ahb_sram_bridge: RTL and testbench
==================================

# ahb_sram_bridge

AHB-Lite slave front-end that drives the single-port word SRAM macro's native port: `write_en`, `read_en`, 4-bit byte `mask`, word `address`, `write_data`/`read_data`. It converts pipelined AHB-Lite address/data phases into SRAM strobes with zero wait states. It generates byte-lane masks from HSIZE/HADDR and answers illegal accesses with the two-cycle AHB ERROR response. It sits between the AHB-Lite interconnect slave port and the SRAM instance.

## Interface
- MEM_DEPTH, 2048: SRAM depth in 32-bit words; ADDR_W = $clog2(MEM_DEPTH)
- DATA_WIDTH, 32: bus/SRAM data width; only 32 is supported
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- hsel  in  1  slave select
- haddr  in  32  byte address (address phase)
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=half, 2=word, >2 illegal
- hready  in  1  bus-level ready (address phase accepted when high)
- hwdata  in  32  write data (data phase)
- hrdata  out  32  read data (data phase)
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- mem_write_en  out  1  to SRAM write_en
- mem_read_en  out  1  to SRAM read_en
- mem_mask  out  4  to SRAM mask, bit i = byte lane i
- mem_address  out  ADDR_W  to SRAM word address
- mem_write_data  out  32  to SRAM write_data
- mem_read_data  in  32  from SRAM read_data (combinational in SRAM)

## Operation
- Transfer accepted when hsel & hready & htrans[1]. IDLE/BUSY or hsel=0 -> no data phase, OKAY, zero wait.
- On acceptance, register word address haddr[ADDR_W+1:2], hwrite, and mask. Classify error if any of:
  - hsize>2
  - hsize=1 with haddr[0]=1
  - hsize=2 with haddr[1:0]!=0
  - any of haddr[31:ADDR_W+2] set (out of range)
- Mask: byte -> 4'b0001<<haddr[1:0]; half -> haddr[1]?4'b1100:4'b0011; word -> 4'b1111.
- FSM states:
  - IDLE: no data phase pending.
  - WR: write data phase. mem_write_en=1, mem_address/mem_mask from registers, mem_write_data=hwdata. hreadyout=1, hresp=0.
  - RD: read data phase. mem_read_en=1, mem_address from register, hrdata=mem_read_data (full word; master selects lanes). hreadyout=1, hresp=0.
  - ERR1: hreadyout=0, hresp=1, no SRAM strobes.
  - ERR2: hreadyout=1, hresp=1, no SRAM strobes.
- Transitions:
  - From IDLE, WR, RD, ERR2: next state is WR, RD, or ERR1 if a transfer is accepted this cycle, else IDLE.
  - ERR1 -> ERR2 unconditionally; any address phase presented during ERR1 is ignored (hready low).
- Outside RD: hrdata=0 and mem_read_en=0. Outside WR: mem_write_en=0, and mem_mask=0 outside WR/RD.
- Errored transfers never touch the SRAM.

## Timing
- Reset values: state IDLE, hreadyout=1, hresp=0, hrdata=0, mem_write_en=0, mem_read_en=0, mem_mask=0, mem_address=0. Reset mid-transfer aborts it: a write in its data phase at the reset edge is not committed.
- Zero wait states for legal transfers. Back-to-back pipelining: the next address phase is accepted in the same cycle as the current data phase.
- Write commits at the rising edge that ends the WR data phase.
- Read data is combinational from the SRAM during the RD cycle. A read immediately following a write to the same word returns the new data; no forwarding is needed.
- ERROR response is exactly 2 cycles (ERR1, ERR2). A transfer accepted in ERR2 proceeds normally.
- hresp and hreadyout depend only on registered state (no combinational path from haddr/htrans).

## Test plan
- Reset: assert reset 3 cycles with htrans=NONSEQ -> hreadyout=1, hresp=0, all mem_* strobes 0. Also assert reset during a WR data phase -> that word is unchanged on readback.
- Word write 0xDEADBEEF @0x10, then word read @0x10 back-to-back -> mem_mask=1111, mem_address=4; read cycle hrdata=0xDEADBEEF, zero wait both.
- Byte write 0xAA @0x13, half write 0x5555 @0x10, word read @0x10 (prior content 0) -> masks 1000 and 0011; hrdata=0xAA005555.
- Unaligned word read @0x02 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); mem_read_en=0 throughout. A following legal read completes OKAY.
- Out-of-range write @ (MEM_DEPTH*4) and hsize=3 write -> each gives a 2-cycle ERROR; SRAM contents unchanged on readback.
- IDLE/BUSY cycles and hsel=0 interleaved with NONSEQ/SEQ writes to 8 consecutive words -> only selected NONSEQ/SEQ produce strobes, all OKAY, and readback matches.

Source files
------------

// File: rtl/ahb_sram_bridge.sv
// ahb_sram_bridge
// AHB-Lite slave front-end for a single-port 32-bit word SRAM macro.
// Zero-wait-state reads and writes, byte/half/word lane masks, and a
// two-cycle ERROR response for misaligned, oversized or out-of-range accesses.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no data phase pending
// WR     | write data phase: SRAM write strobe with registered address/mask
// RD     | read data phase: SRAM read strobe, hrdata straight from the macro
// ERR1   | first ERROR cycle: hreadyout low, hresp high, no SRAM strobes
// ERR2   | second ERROR cycle: hreadyout high, hresp high, no SRAM strobes

module ahb_sram_bridge #(
    parameter  int MEM_DEPTH  = 2048,
    parameter  int DATA_WIDTH = 32,   // only 32 is supported
    localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [3:0]            mem_mask,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              access_err;
    logic [3:0]        mask_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        mask_q;

    // htrans[0] only separates NONSEQ from SEQ (and IDLE from BUSY); both
    // halves of each pair are treated alike here.
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = htrans[0];

    // Address-phase decode: acceptance, lane mask and illegal-access classification.
    always_comb begin
        accept     = hsel & hready & htrans[1];
        mask_nxt   = 4'b0000;
        access_err = |haddr[31:ADDR_W+2];
        case (hsize)
            3'd0: mask_nxt = 4'b0001 << haddr[1:0];
            3'd1: begin
                mask_nxt = haddr[1] ? 4'b1100 : 4'b0011;
                if (haddr[0]) access_err = 1'b1;
            end
            3'd2: begin
                mask_nxt = 4'b1111;
                if (haddr[1:0] != 2'b00) access_err = 1'b1;
            end
            default: access_err = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Capture word address and lane mask of each legal accepted transfer.
    // ERR1 is excluded: hready is low there, so nothing is really presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            mask_q <= 4'b0000;
        end else if (accept && !access_err && state != S_ERR1) begin
            addr_q <= haddr[ADDR_W+1:2];
            mask_q <= mask_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = S_IDLE;
        if (state == S_ERR1) begin
            state_nxt = S_ERR2;
        end else if (accept) begin
            if (access_err)  state_nxt = S_ERR1;
            else if (hwrite) state_nxt = S_WR;
            else             state_nxt = S_RD;
        end
    end

    // Outputs decoded from registered state. SRAM strobes are also masked by
    // reset so a data phase caught by reset never commits a write.
    always_comb begin
        hreadyout      = 1'b1;
        hresp          = 1'b0;
        hrdata         = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_mask       = 4'b0000;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            S_WR: begin
                mem_write_en   = ~reset;
                mem_mask       = mask_q;
                mem_address    = addr_q;
                mem_write_data = hwdata;
            end
            S_RD: begin
                mem_read_en = ~reset;
                mem_mask    = mask_q;
                mem_address = addr_q;
                hrdata      = mem_read_data;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: begin
                hresp = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb_ahb_sram_bridge
// Directed bench for ahb_sram_bridge with a behavioural byte-masked SRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_ahb_sram_bridge;

    localparam int MEM_DEPTH = 2048;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic              clk = 1'b0;
    logic              reset;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic              hready;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hreadyout;
    logic              hresp;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [3:0]        mem_mask;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sram [MEM_DEPTH];

    // Interleave pattern: select, transfer type, word offset, hand-marked acceptance.
    int seq_sel   [14] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    int seq_trans [14] = '{2, 1, 3, 2, 3, 0, 2, 3, 3, 3, 1, 3, 3, 0};
    int seq_off   [14] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 5, 6, 6, 7, 0};
    int seq_acc   [14] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0};

    always #5 clk = ~clk;

    // Single slave on the bus: the bus-level ready is this slave's ready.
    assign hready = hreadyout;

    ahb_sram_bridge #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .hsel           (hsel),
        .haddr          (haddr),
        .htrans         (htrans),
        .hwrite         (hwrite),
        .hsize          (hsize),
        .hready         (hready),
        .hwdata         (hwdata),
        .hrdata         (hrdata),
        .hreadyout      (hreadyout),
        .hresp          (hresp),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_mask       (mem_mask),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // SRAM macro model: byte-masked synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) sram[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
    end
    assign mem_read_data = sram[mem_address];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hwdata = wdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            n_tests++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout[%0d]: got %b want 1", k, hreadyout); end
            n_tests++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp[%0d]: got %b want 0", k, hresp); end
            n_tests++; if ({mem_write_en, mem_read_en} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes[%0d]: got %b want 00", k, {mem_write_en, mem_read_en}); end
            n_tests++; if (mem_mask !== 4'b0000 || mem_address !== '0) begin n_fail++; $display("FAIL reset_mask_addr[%0d]: got %b/%0d want 0000/0", k, mem_mask, mem_address); end
            n_tests++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata[%0d]: got %h want 0", k, hrdata); end
        end
        reset = 1'b0;
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        cyc();
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got rdy=%b resp=%b we=%b want 1 0 0", hreadyout, hresp, mem_write_en); end
    endtask

    task automatic test_reset_mid_write();
        cyc();
        drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h0);
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h1234_5678);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b1 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_idle: got rdy=%b we=%b want 1 0", hreadyout, mem_write_en); end
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (hrdata !== 32'h0 || mem_read_en !== 1'b1) begin n_fail++; $display("FAIL rst_wr_readback: got %h re=%b want 00000000 re=1", hrdata, mem_read_en); end
    endtask

    task automatic test_word_rw();
        cyc();
        drive(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
        @(negedge clk);
        n_tests++; if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0) begin n_fail++; $display("FAIL word_addr_phase: got we=%b re=%b want 0 0", mem_write_en, mem_read_en); end
        cyc();
        drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        n_tests++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin n_fail++; $display("FAIL word_wr_strobe: got we=%b re=%b want 1 0", mem_write_en, mem_read_en); end
        n_tests++; if (mem_mask !== 4'b1111) begin n_fail++; $display("FAIL word_wr_mask: got %b want 1111", mem_mask); end
        n_tests++; if (mem_address !== 11'd4) begin n_fail++; $display("FAIL word_wr_addr: got %0d want 4", mem_address); end
        n_tests++; if (mem_write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_wr_data: got %h want deadbeef", mem_write_data); end
        n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL word_wr_resp: got rdy=%b resp=%b want 1 0", hreadyout, hresp); end
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL word_rd_strobe: got re=%b we=%b want 1 0", mem_read_en, mem_write_en); end
        n_tests++; if (mem_address !== 11'd4) begin n_fail++; $display("FAIL word_rd_addr: got %0d want 4", mem_address); end
        n_tests++; if (hrdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_rd_data: got %h want deadbeef", hrdata); end
        n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL word_rd_resp: got rdy=%b resp=%b want 1 0", hreadyout, hresp); end
        cyc();
        @(negedge clk);
        n_tests++; if (mem_read_en !== 1'b0 || hrdata !== 32'h0 || mem_mask !== 4'b0000) begin n_fail++; $display("FAIL word_after_idle: got re=%b hrdata=%h mask=%b want 0 0 0000", mem_read_en, hrdata, mem_mask); end
    endtask

    task automatic test_byte_half();
        cyc();
        drive(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h33, 32'h0);
        cyc();
        drive(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h30, 32'hAA00_0000);
        @(negedge clk);
        n_tests++; if (mem_mask !== 4'b1000) begin n_fail++; $display("FAIL byte_mask: got %b want 1000", mem_mask); end
        n_tests++; if (mem_address !== 11'd12 || mem_write_en !== 1'b1) begin n_fail++; $display("FAIL byte_addr: got %0d we=%b want 12 we=1", mem_address, mem_write_en); end
        cyc();
        drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0000_5555);
        @(negedge clk);
        n_tests++; if (mem_mask !== 4'b0011) begin n_fail++; $display("FAIL half_mask: got %b want 0011", mem_mask); end
        n_tests++; if (mem_address !== 11'd12 || mem_write_en !== 1'b1) begin n_fail++; $display("FAIL half_addr: got %0d we=%b want 12 we=1", mem_address, mem_write_en); end
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (hrdata !== 32'hAA00_5555) begin n_fail++; $display("FAIL byte_half_read: got %h want aa005555", hrdata); end
        n_tests++; if (mem_mask !== 4'b1111 || hresp !== 1'b0) begin n_fail++; $display("FAIL byte_half_rd_mask: got %b resp=%b want 1111 0", mem_mask, hresp); end
    endtask

    task automatic test_unaligned_error();
        cyc();
        drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h02, 32'h0);
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL unal_err1: got rdy=%b resp=%b want 0 1", hreadyout, hresp); end
        n_tests++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL unal_err1_strobe: got re=%b we=%b want 0 0", mem_read_en, mem_write_en); end
        cyc();
        drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL unal_err2: got rdy=%b resp=%b want 1 1", hreadyout, hresp); end
        n_tests++; if (mem_read_en !== 1'b0 || hrdata !== 32'h0) begin n_fail++; $display("FAIL unal_err2_strobe: got re=%b hrdata=%h want 0 0", mem_read_en, hrdata); end
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (hresp !== 1'b0 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL unal_next_resp: got rdy=%b resp=%b want 1 0", hreadyout, hresp); end
        n_tests++; if (hrdata !== 32'hAA00_5555 || mem_read_en !== 1'b1) begin n_fail++; $display("FAIL unal_next_data: got %h re=%b want aa005555 1", hrdata, mem_read_en); end
    endtask

    task automatic test_range_size_error();
        cyc();
        drive(1'b1, T_NONSEQ, 1'b1, 3'd2, MEM_DEPTH * 4, 32'h0);
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b0 || hresp !== 1'b1 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL range_err1: got rdy=%b resp=%b we=%b want 0 1 0", hreadyout, hresp, mem_write_en); end
        cyc();
        drive(1'b1, T_NONSEQ, 1'b1, 3'd3, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b1 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL range_err2: got rdy=%b resp=%b we=%b want 1 1 0", hreadyout, hresp, mem_write_en); end
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b0 || hresp !== 1'b1 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL size_err1: got rdy=%b resp=%b we=%b want 0 1 0", hreadyout, hresp, mem_write_en); end
        cyc();
        drive(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b1 || mem_write_en !== 1'b0) begin n_fail++; $display("FAIL size_err2: got rdy=%b resp=%b we=%b want 1 1 0", hreadyout, hresp, mem_write_en); end
        cyc();
        drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        @(negedge clk);
        n_tests++; if (hrdata !== 32'h0 || hresp !== 1'b0 || mem_read_en !== 1'b1) begin n_fail++; $display("FAIL err_readback: got %h resp=%b re=%b want 00000000 0 1", hrdata, hresp, mem_read_en); end
    endtask

    task automatic test_interleave();
        logic        pend;
        int          pword;
        logic [31:0] wdata;
        pend  = 1'b0;
        pword = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            wdata = pend ? (32'hC0DE_0000 + 32'(pword)) : 32'h0;
            drive(seq_sel[i][0], seq_trans[i][1:0], 1'b1, 3'd2, 32'h40 + 32'(seq_off[i] * 4), wdata);
            @(negedge clk);
            n_tests++; if (mem_write_en !== pend) begin n_fail++; $display("FAIL ilv_we[%0d]: got %b want %b", i, mem_write_en, pend); end
            n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL ilv_resp[%0d]: got rdy=%b resp=%b want 1 0", i, hreadyout, hresp); end
            if (pend) begin
                n_tests++; if (mem_address !== ADDR_W'(16 + pword) || mem_write_data !== wdata) begin n_fail++; $display("FAIL ilv_wr[%0d]: got addr=%0d data=%h want %0d %h", i, mem_address, mem_write_data, 16 + pword, wdata); end
            end
            pend  = (seq_acc[i] != 0);
            pword = seq_off[i];
        end
        for (int j = 0; j <= 8; j++) begin
            cyc();
            if (j < 8) drive(1'b1, (j == 0) ? T_NONSEQ : T_SEQ, 1'b0, 3'd2, 32'h40 + 32'(j * 4), 32'h0);
            else       drive(1'b1, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
            @(negedge clk);
            if (j > 0) begin
                n_tests++; if (hrdata !== 32'hC0DE_0000 + 32'(j - 1)) begin n_fail++; $display("FAIL ilv_readback[%0d]: got %h want %h", j - 1, hrdata, 32'hC0DE_0000 + 32'(j - 1)); end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < MEM_DEPTH; a++) sram[a] = 32'h0;
        reset = 1'b1;
        drive(1'b0, T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        test_reset();
        test_reset_mid_write();
        test_word_rw();
        test_byte_half();
        test_unaligned_error();
        test_range_size_error();
        test_interleave();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
